// File: rtl/piece_window_scanner_if.sv
// Bundle between the piece window scanner, gameplay control, the piece ROM and the playfield RAM.
// The slave side is the scanner; the master side is everything around it.
interface piece_window_scanner_if;
  logic       start;
  logic       mode;
  logic [4:0] piece_id;
  logic [4:0] pos_x;
  logic [5:0] pos_y;
  logic [4:0] rom_identifier;
  logic [2:0] rom_col;
  logic [2:0] rom_row;
  logic [1:0] rom_template;
  logic [7:0] board_addr;
  logic [1:0] board_rd_data;
  logic       board_we;
  logic [1:0] board_wr_data;
  logic       busy;
  logic       done;
  logic       collision;

  modport master (
    output start, mode, piece_id, pos_x, pos_y, rom_template, board_rd_data,
    input  rom_identifier, rom_col, rom_row, board_addr, board_we, board_wr_data,
           busy, done, collision
  );

  modport slave (
    input  start, mode, piece_id, pos_x, pos_y, rom_template, board_rd_data,
    output rom_identifier, rom_col, rom_row, board_addr, board_we, board_wr_data,
           busy, done, collision
  );
endinterface

// File: rtl/piece_window_scanner.sv
// Walks the 4x4 piece window through the ROM and either checks the placed piece
// for collision against the playfield (CHECK) or stamps it into the playfield (STAMP).
module piece_window_scanner #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input logic                   clk,
  input logic                   reset,
  piece_window_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic signed [5:0] W_S = 6'(BOARD_W);
  localparam logic signed [6:0] H_S = 7'(BOARD_H);

  state_t            state;
  logic [3:0]        k;
  logic              mode_q;
  logic [4:0]        id_q;
  logic signed [4:0] px_q;
  logic signed [5:0] py_q;
  logic              busy_q, done_q, coll_q;
  logic              on_q, inb_q, oob_q, cmp_vld;

  logic              scan;
  logic signed [5:0] bc;
  logic signed [6:0] br;
  logic              on, above, oob, inb;
  logic [7:0]        addr;

  always_comb begin
    scan  = (state == SCAN);
    bc    = {px_q[4], px_q} + {4'b0, k[1:0]};
    br    = {py_q[5], py_q} + {5'b0, k[3:2]};
    on    = (bus.rom_template != 2'b11);
    above = br[6];
    // Cells above the board are neither in-board nor out of bounds.
    oob   = !above && (bc[5] || (bc >= W_S) || (br >= H_S));
    inb   = !above && !oob;
    addr  = {3'b0, br[4:0]} * 8'(BOARD_W) + {4'b0, bc[3:0]};

    bus.board_addr    = 8'd0;
    bus.board_we      = 1'b0;
    bus.board_wr_data = 2'b11;
    if (scan && inb) begin
      if (!mode_q) begin
        bus.board_addr = addr;
      end else if (on) begin
        bus.board_addr    = addr;
        bus.board_we      = 1'b1;
        bus.board_wr_data = bus.rom_template;
      end
    end

    bus.rom_col = scan ? {1'b0, k[1:0]} : 3'd4;
    bus.rom_row = scan ? {1'b0, k[3:2]} : 3'd0;
  end

  assign bus.rom_identifier = id_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.collision      = coll_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= 4'd0;
      mode_q  <= 1'b0;
      id_q    <= 5'd0;
      px_q    <= 5'sd0;
      py_q    <= 6'sd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
      on_q    <= 1'b0;
      inb_q   <= 1'b0;
      oob_q   <= 1'b0;
      cmp_vld <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      // CHECK compare runs one cycle behind the address, when RAM data lands.
      cmp_vld <= scan && !mode_q;
      on_q    <= on;
      inb_q   <= inb;
      oob_q   <= oob;
      if (cmp_vld && on_q && (oob_q || (inb_q && bus.board_rd_data != 2'b11)))
        coll_q <= 1'b1;

      case (state)
        IDLE: if (bus.start) begin
          state  <= SCAN;
          mode_q <= bus.mode;
          id_q   <= bus.piece_id;
          px_q   <= bus.pos_x;
          py_q   <= bus.pos_y;
          k      <= 4'd0;
          coll_q <= 1'b0;
          busy_q <= 1'b1;
        end
        SCAN: begin
          if (mode_q && on && oob) coll_q <= 1'b1;
          k <= k + 4'd1;
          if (k == 4'd15) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
